// File: rtl/bus_pkg.sv
// Shared bus definitions used by the arbiter and by the initiator/target ports.
package bus_pkg;

  localparam int MAX_INIT = 16;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    HANDOVER
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set bit of mask at or above ptr, wrapping around.
module rr_picker #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [N-1:0] rotated;
  int           src;
  int           off;
  int           sum;

  // Rotate so ptr lands on bit 0, priority-encode, then rotate the index back.
  always_comb begin
    rotated = '0;
    src     = 0;
    off     = 0;
    for (int i = 0; i < N; i++) begin
      src = int'(ptr) + i;
      if (src >= N) src = src - N;
      rotated[i] = mask[IDW'(src)];
    end
    found = |rotated;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) off = i;
    end
    sum = int'(ptr) + off;
    if (sum >= N) sum = sum - N;
    idx = IDW'(sum);
  end

endmodule

// File: rtl/bus_split_arbiter.sv
// Round-robin bus arbiter with registered one-hot grants, a dead handover
// cycle between grants, and split-transaction parking / priority resume.
module bus_split_arbiter
  import bus_pkg::*;
#(
  parameter  int N_INIT = 4,
  localparam int IDW    = $clog2(N_INIT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_INIT-1:0] req,
  input  logic              target_split,
  input  logic              split_done,
  input  logic [IDW-1:0]    split_id,
  output logic [N_INIT-1:0] grant,
  output logic              grant_valid,
  output logic [IDW-1:0]    grant_id,
  output logic [N_INIT-1:0] split_pending,
  output logic              split_err
);

  if (N_INIT < 2 || N_INIT > MAX_INIT) begin : g_bad_n_init
    $error("bus_split_arbiter: N_INIT out of range");
  end

  arb_state_t        state, state_n;
  logic [N_INIT-1:0] grant_n, pend_n, elig;
  logic [IDW-1:0]    grant_id_n, rr_ptr, rr_ptr_n, resume_id, resume_id_n;
  logic [IDW-1:0]    pick_idx, winner;
  logic              resume_valid, resume_valid_n, err_n;
  logic              pick_found, resume_hit, split_id_ok;

  assign elig        = req & ~split_pending;
  assign resume_hit  = resume_valid && elig[resume_id];
  assign winner      = resume_hit ? resume_id : pick_idx;
  assign split_id_ok = int'(split_id) < N_INIT;

  rr_picker #(.N(N_INIT)) u_rr_picker (
    .mask  (elig),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n        = state;
    grant_n        = grant;
    grant_id_n     = grant_id;
    pend_n         = split_pending;
    rr_ptr_n       = rr_ptr;
    resume_valid_n = resume_valid;
    resume_id_n    = resume_id;
    err_n          = 1'b0;

    case (state)
      GRANT: begin
        if (target_split) begin
          pend_n[grant_id] = 1'b1;
          grant_n          = '0;
          state_n          = HANDOVER;
        end else if (!req[grant_id]) begin
          grant_n = '0;
          state_n = HANDOVER;
        end
      end
      default: begin
        // IDLE and HANDOVER both arbitrate; the HANDOVER cycle itself is the
        // single dead cycle, so a waiting requester is granted right after it.
        if (target_split) err_n = 1'b1;
        if (pick_found) begin
          grant_n         = '0;
          grant_n[winner] = 1'b1;
          grant_id_n      = winner;
          rr_ptr_n        = (int'(winner) == N_INIT - 1) ? '0 : winner + 1'b1;
          state_n         = GRANT;
          if (resume_hit) resume_valid_n = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
    endcase

    // Judged against the flags as they stood before this cycle's split.
    if (split_done) begin
      if (split_id_ok && split_pending[split_id]) begin
        pend_n[split_id] = 1'b0;
        resume_valid_n   = 1'b1;
        resume_id_n      = split_id;
      end else begin
        err_n = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_id      <= '0;
      split_pending <= '0;
      split_err     <= 1'b0;
      rr_ptr        <= '0;
      resume_valid  <= 1'b0;
      resume_id     <= '0;
    end else begin
      state         <= state_n;
      grant         <= grant_n;
      grant_valid   <= |grant_n;
      grant_id      <= grant_id_n;
      split_pending <= pend_n;
      split_err     <= err_n;
      rr_ptr        <= rr_ptr_n;
      resume_valid  <= resume_valid_n;
      resume_id     <= resume_id_n;
    end
  end

endmodule

// File: tb/tb_bus_split_arbiter.sv
// Bench for bus_split_arbiter: directed scenarios plus random traffic scored
// against a cycle-level behavioural model of the arbitration rules.
module tb_bus_split_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic           target_split;
  logic           split_done;
  logic [IDW-1:0] split_id;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic [N-1:0]   split_pending;
  logic           split_err;

  int n_cmp  = 0;
  int n_fail = 0;

  bus_split_arbiter #(.N_INIT(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .target_split  (target_split),
    .split_done    (split_done),
    .split_id      (split_id),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .split_pending (split_pending),
    .split_err     (split_err)
  );

  always #5 clk = ~clk;

  // Inputs change at a negedge; outputs are read at the following negedge.
  task automatic apply(input logic [N-1:0] r, input logic ts, input logic sd,
                       input logic [IDW-1:0] sid);
    req          = r;
    target_split = ts;
    split_done   = sd;
    split_id     = sid;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    req          = '0;
    target_split = 1'b0;
    split_done   = 1'b0;
    split_id     = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({grant, grant_valid, grant_id, split_pending, split_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: grant=%b valid=%b id=%0d pend=%b err=%b, all zero required",
               grant, grant_valid, grant_id, split_pending, split_err);
    end
  endtask

  task automatic test_basic();
    do_reset();
    apply(4'b0000, 1'b0, 1'b0, 2'd0);
    n_cmp++;
    if ({grant, split_pending} !== 8'h00) begin
      n_fail++; $display("FAIL basic_idle: grant=%b pend=%b, 0000/0000 required", grant, split_pending);
    end
    apply(4'b0110, 1'b0, 1'b0, 2'd0);
    n_cmp++;
    if ({grant, grant_valid, grant_id} !== {4'b0010, 1'b1, 2'd1}) begin
      n_fail++; $display("FAIL basic_first_grant: grant=%b valid=%b id=%0d, 0010/1/1 required", grant, grant_valid, grant_id);
    end
    apply(4'b0110, 1'b0, 1'b0, 2'd0);
    n_cmp++;
    if (grant !== 4'b0010) begin
      n_fail++; $display("FAIL basic_hold: grant=%b, 0010 required", grant);
    end
    apply(4'b0100, 1'b0, 1'b0, 2'd0);
    n_cmp++;
    if ({grant, grant_valid, grant_id} !== {4'b0000, 1'b0, 2'd1}) begin
      n_fail++; $display("FAIL basic_handover: grant=%b valid=%b id=%0d, 0000/0/1 required", grant, grant_valid, grant_id);
    end
    apply(4'b0100, 1'b0, 1'b0, 2'd0);
    n_cmp++;
    if ({grant, grant_id} !== {4'b0100, 2'd2}) begin
      n_fail++; $display("FAIL basic_second_grant: grant=%b id=%0d, 0100/2 required", grant, grant_id);
    end
    apply(4'b0000, 1'b0, 1'b0, 2'd0);
    apply(4'b0000, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % N);
      for (int c = 0; c < 3; c++) begin
        apply(4'b1111, 1'b0, 1'b0, 2'd0);
        n_cmp++;
        if (grant !== exp_g) begin
          n_fail++; $display("FAIL rr_grant k=%0d c=%0d: grant=%b, %b required", k, c, grant, exp_g);
        end
      end
      apply(4'b1111 & ~exp_g, 1'b0, 1'b0, 2'd0);
      n_cmp++;
      if (grant !== 4'b0000) begin
        n_fail++; $display("FAIL rr_gap k=%0d: grant=%b, 0000 required", k, grant);
      end
    end
    apply(4'b0000, 1'b0, 1'b0, 2'd0);
    apply(4'b0000, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_split();
    do_reset();
    apply(4'b0100, 1'b0, 1'b0, 2'd0);
    n_cmp++;
    if (grant !== 4'b0100) begin
      n_fail++; $display("FAIL split_first_grant: grant=%b, 0100 required", grant);
    end
    apply(4'b1111, 1'b1, 1'b0, 2'd0);
    n_cmp++;
    if ({grant, split_pending, split_err} !== {4'b0000, 4'b0100, 1'b0}) begin
      n_fail++; $display("FAIL split_park: grant=%b pend=%b err=%b, 0000/0100/0 required", grant, split_pending, split_err);
    end
    apply(4'b1111, 1'b0, 1'b0, 2'd0);
    n_cmp++;
    if (grant !== 4'b1000) begin
      n_fail++; $display("FAIL split_next_grant: grant=%b, 1000 required", grant);
    end
    apply(4'b1111, 1'b0, 1'b1, 2'd2);
    n_cmp++;
    if ({grant, split_pending, split_err} !== {4'b1000, 4'b0000, 1'b0}) begin
      n_fail++; $display("FAIL split_done: grant=%b pend=%b err=%b, 1000/0000/0 required", grant, split_pending, split_err);
    end
    apply(4'b0111, 1'b0, 1'b0, 2'd0);
    apply(4'b0111, 1'b0, 1'b0, 2'd0);
    n_cmp++;
    if ({grant, grant_id} !== {4'b0100, 2'd2}) begin
      n_fail++; $display("FAIL split_resume_priority: grant=%b id=%0d, 0100/2 required", grant, grant_id);
    end
    apply(4'b0011, 1'b0, 1'b0, 2'd0);
    apply(4'b0011, 1'b0, 1'b0, 2'd0);
    n_cmp++;
    if (grant !== 4'b0001) begin
      n_fail++; $display("FAIL split_after_resume: grant=%b, 0001 required", grant);
    end
    apply(4'b0000, 1'b0, 1'b0, 2'd0);
    apply(4'b0000, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_illegal();
    do_reset();
    apply(4'b0000, 1'b0, 1'b1, 2'd1);
    n_cmp++;
    if ({split_err, split_pending} !== {1'b1, 4'b0000}) begin
      n_fail++; $display("FAIL illegal_done: err=%b pend=%b, 1/0000 required", split_err, split_pending);
    end
    apply(4'b0000, 1'b0, 1'b0, 2'd0);
    n_cmp++;
    if (split_err !== 1'b0) begin
      n_fail++; $display("FAIL illegal_done_pulse: err=%b, 0 required", split_err);
    end
    apply(4'b0000, 1'b1, 1'b0, 2'd0);
    n_cmp++;
    if ({split_err, grant} !== {1'b1, 4'b0000}) begin
      n_fail++; $display("FAIL illegal_split_idle: err=%b grant=%b, 1/0000 required", split_err, grant);
    end
    apply(4'b0000, 1'b0, 1'b0, 2'd0);
    n_cmp++;
    if (split_err !== 1'b0) begin
      n_fail++; $display("FAIL illegal_split_pulse: err=%b, 0 required", split_err);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    apply(4'b0100, 1'b0, 1'b0, 2'd0);
    apply(4'b0100, 1'b1, 1'b1, 2'd2);
    n_cmp++;
    if ({split_err, split_pending, grant} !== {1'b1, 4'b0100, 4'b0000}) begin
      n_fail++; $display("FAIL same_cycle: err=%b pend=%b grant=%b, 1/0100/0000 required", split_err, split_pending, grant);
    end
    apply(4'b0100, 1'b0, 1'b0, 2'd0);
    apply(4'b0100, 1'b0, 1'b0, 2'd0);
    n_cmp++;
    if ({split_err, grant} !== {1'b0, 4'b0000}) begin
      n_fail++; $display("FAIL parked_not_granted: err=%b grant=%b, 0/0000 required", split_err, grant);
    end
    apply(4'b0000, 1'b0, 1'b0, 2'd0);
    n_cmp++;
    if (split_pending !== 4'b0100) begin
      n_fail++; $display("FAIL parked_drop_req: pend=%b, 0100 required", split_pending);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    apply(4'b0100, 1'b0, 1'b0, 2'd0);
    apply(4'b1100, 1'b1, 1'b0, 2'd0);
    apply(4'b1100, 1'b0, 1'b0, 2'd0);
    n_cmp++;
    if ({grant, split_pending} !== {4'b1000, 4'b0100}) begin
      n_fail++; $display("FAIL areset_setup: grant=%b pend=%b, 1000/0100 required", grant, split_pending);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({grant, grant_valid, split_pending} !== '0) begin
      n_fail++; $display("FAIL areset_async: grant=%b valid=%b pend=%b, all zero required", grant, grant_valid, split_pending);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'b1100, 1'b0, 1'b0, 2'd0);
    n_cmp++;
    if ({grant, grant_id} !== {4'b0100, 2'd2}) begin
      n_fail++; $display("FAIL areset_regrant: grant=%b id=%0d, 0100/2 required", grant, grant_id);
    end
  endtask

  task automatic test_random();
    int           owner, last, ptr, res_id, win, sid;
    bit           res_v, ts, sd, exp_err;
    logic [N-1:0] park, new_park, r, exp_g;
    do_reset();
    owner = -1; last = 0; ptr = 0; res_v = 1'b0; res_id = 0; park = '0; r = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (owner == i && r[i] && $urandom_range(3) == 0) r[i] = 1'b0;
        else if (!r[i] && $urandom_range(2) == 0) r[i] = 1'b1;
        else if (park[i] && r[i] && $urandom_range(7) == 0) r[i] = 1'b0;
      end
      ts  = ($urandom_range(5) == 0);
      sd  = ($urandom_range(4) == 0);
      sid = int'($urandom_range(N - 1));

      exp_err  = 1'b0;
      new_park = park;
      if (owner >= 0) begin
        if (ts) begin
          new_park[owner] = 1'b1;
          owner = -1;
        end else if (!r[owner]) begin
          owner = -1;
        end
      end else begin
        if (ts) exp_err = 1'b1;
        win = -1;
        if (res_v && r[res_id] && !park[res_id]) begin
          win   = res_id;
          res_v = 1'b0;
        end else begin
          for (int k = 0; k < N; k++)
            if (win < 0 && r[(ptr + k) % N] && !park[(ptr + k) % N]) win = (ptr + k) % N;
        end
        if (win >= 0) begin
          owner = win;
          last  = win;
          ptr   = (win + 1) % N;
        end
      end
      if (sd) begin
        if (park[sid]) begin
          new_park[sid] = 1'b0;
          res_v  = 1'b1;
          res_id = sid;
        end else begin
          exp_err = 1'b1;
        end
      end
      park = new_park;

      apply(r, ts, sd, IDW'(sid));
      exp_g = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
      n_cmp++;
      if ({grant, grant_valid, grant_id, split_pending, split_err} !==
          {exp_g, owner >= 0, IDW'(last), park, exp_err}) begin
        n_fail++;
        $display("FAIL random cyc=%0d: grant=%b valid=%b id=%0d pend=%b err=%b; required %b/%b/%0d/%b/%b",
                 cyc, grant, grant_valid, grant_id, split_pending, split_err,
                 exp_g, owner >= 0, last, park, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_split();
    test_illegal();
    test_same_cycle();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_split_arbiter.md
Name: bus_split_arbiter

Overview:
- Central arbiter for the shared serial bus.
- Takes per-initiator arbiter_req lines from the initiator ports and returns one-hot registered grants.
- Grants are round-robin. Every grant change inserts one dead handover cycle.
- Supports split transactions:
  - A target split parks the granted initiator and frees the bus.
  - A later split-done from the target re-admits that initiator with top priority.

Parameters:
- N_INIT, 4: number of initiators; legal range 2..16.
- IDW, $clog2(N_INIT): localparam, not overridable; width of initiator id fields.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N_INIT  per-initiator bus request; level, held for the whole transaction
- target_split  input  1  one-cycle pulse; the target splits the current transaction
- split_done  input  1  one-cycle pulse; the target is ready to complete a split transaction
- split_id  input  IDW  initiator id that split_done refers to
- grant  output  N_INIT  one-hot or zero, registered
- grant_valid  output  1  OR of grant, registered
- grant_id  output  IDW  index of the granted initiator; holds its last value when grant_valid=0
- split_pending  output  N_INIT  per-initiator parked flags
- split_err  output  1  one-cycle pulse on an illegal split event

Behaviour:
- Reset values: grant=0, grant_valid=0, grant_id=0, split_pending=0, split_err=0, state=IDLE, rr_ptr=0, resume_valid=0, resume_id=0.
- State machine: IDLE, GRANT, HANDOVER.
- Eligible set: elig = req & ~split_pending.
- IDLE:
  - If elig is non-zero, choose a winner and register it; state goes to GRANT.
  - Latency: req seen high in IDLE at edge t gives grant high after edge t.
  - Winner selection:
    - If resume_valid and elig[resume_id], the winner is resume_id and resume_valid clears.
    - Otherwise the winner is the first set bit of elig, searching upward from rr_ptr with wrap.
    - resume_valid stays set while resume_id is not requesting.
  - On grant, rr_ptr = winner+1 mod N_INIT.
- GRANT (granted index g):
  - target_split=1: split_pending[g] sets, grant clears, state goes to HANDOVER.
  - Else if req[g]=0: grant clears, state goes to HANDOVER.
  - Else: hold the grant. There is no timeout.
  - Split takes priority when split and req-drop happen in the same cycle.
- HANDOVER: exactly one cycle with grant=0, then IDLE.
  - Minimum gap between two grants is therefore 1 cycle, with no grant overlap.
- target_split while not in GRANT: ignored; split_err pulses.
- split_done, accepted in any state:
  - If split_pending[split_id]=1: the bit clears, resume_valid sets and resume_id is set to split_id.
  - If split_pending[split_id]=0: no state change; split_err pulses.
  - If resume_valid is already set: the new split_done overwrites resume_id. Only the most recent resume is favoured.
  - split_id ≥ N_INIT is treated as not pending and raises split_err.
- Simultaneous events:
  - target_split for g and split_done for the same g in one cycle: split_done is evaluated against the pre-cycle flags, so split_err pulses and split_pending[g] ends at 1.
  - split_done for a different id in the same cycle: both take effect.
- Parked initiators:
  - A parked initiator that keeps req high is never granted until its split_done.
  - A parked initiator that drops req stays parked.
- Reset asserted mid-grant: all outputs return to reset values on the asynchronous edge. Parked state is lost.
- grant is only ever driven from registers, never combinationally from req.

Decomposition:
- bus_pkg (shared with the initiator and target ports):
  - arb_state_t enum {IDLE, GRANT, HANDOVER}
  - constant MAX_INIT=16
- Sub-module rr_picker: combinational, parameter N.
  - Inputs: mask[N], ptr[IDW].
  - Outputs: found, idx[IDW].
  - Implementation: rotate-then-priority-encode.
- The top module holds the FSM, the split flags and the resume logic.

Test Plan (N_INIT=4):
1. Reset then req=4'b0000 -> grant=0, split_pending=0. Then req=4'b0110 -> grant=4'b0010 one cycle later. Drop req[1] -> one cycle grant=0, then grant=4'b0100.
2. Round-robin fairness: all req held high, each initiator drops req after 3 granted cycles -> grant order 0,1,2,3,0, each grant separated by exactly one zero cycle.
3. Split: grant to 2, then pulse target_split -> split_pending=4'b0100, next grant=4'b1000 while req[2] stays high. Pulse split_done with split_id=2 during the grant to 3 -> after 3 releases, grant=4'b0100 ahead of the waiting 0 and 1.
4. Illegal events:
   - split_done with split_id=1 while not pending -> split_err single pulse, no flag change.
   - target_split in IDLE -> split_err pulse.
5. Same-cycle target_split for 2 and split_done with split_id=2 -> split_err pulse, split_pending[2]=1.
6. rst_n asserted mid-GRANT with a parked initiator -> grant, split_pending and grant_valid go to 0 asynchronously. After reset, the lowest requester from rr_ptr=0 is granted.
